// File: rtl/usbf_sie_ep_mps.sv
// USB device endpoint between the SIE and the Rx/Tx FIFOs: splits IN transfers into
// max-packet-size packets (plus optional ZLP), tracks DATA0/1 toggles and polices OUT sizes.
module usbf_sie_ep_mps #(
    parameter int LEN_W   = 11,
    parameter int MAX_PKT = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ep_stall_i,
    input  logic             ep_toggle_clr_i,
    output logic             rx_space_o,
    input  logic             rx_setup_i,
    input  logic             rx_valid_i,
    input  logic             rx_strb_i,
    input  logic [7:0]       rx_data_i,
    input  logic             rx_last_i,
    input  logic             rx_crc_err_i,
    input  logic             rx_pid_data1_i,
    output logic             rx_push_o,
    output logic [7:0]       rx_data_o,
    input  logic             rx_full_i,
    output logic [LEN_W-1:0] rx_length_o,
    output logic             rx_ready_o,
    output logic             rx_err_o,
    output logic             rx_setup_o,
    output logic             rx_dup_o,
    input  logic             rx_ack_i,
    output logic             tx_pop_o,
    input  logic [7:0]       tx_data_i,
    input  logic             tx_empty_i,
    input  logic             tx_flush_i,
    input  logic [LEN_W-1:0] tx_length_i,
    input  logic             tx_zlp_en_i,
    input  logic             tx_start_i,
    output logic             tx_busy_o,
    output logic             tx_err_o,
    output logic             tx_done_o,
    output logic             tx_ready_o,
    output logic             tx_data_valid_o,
    output logic             tx_data_strb_o,
    output logic [7:0]       tx_data_o,
    output logic             tx_data_last_o,
    input  logic             tx_data_accept_i,
    output logic             tx_pid_data1_o,
    input  logic             tx_hs_ack_i,
    input  logic             tx_hs_timeout_i
);
    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_PKT);
    localparam logic [LEN_W-1:0] ONE_L = LEN_W'(1);

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_WAIT_HS} tx_state_t;

    function automatic logic [LEN_W-1:0] pkt_size(input logic [LEN_W-1:0] rem);
        return (rem < MAX_L) ? rem : MAX_L;
    endfunction

    logic [LEN_W-1:0] rx_len_q, rx_len_d;
    logic             rx_ready_q, rx_ready_d;
    logic             rx_err_q, rx_err_d;
    logic             rx_setup_q, rx_setup_d;
    logic             rx_dup_q, rx_dup_d;
    logic             rx_tog_q, rx_tog_d;
    logic             tx_tog_q, tx_tog_d;
    tx_state_t        state_q, state_d;
    logic [LEN_W-1:0] remain_q, remain_d;
    logic [LEN_W-1:0] pkt_q, pkt_d;
    logic             zlp_pend_q, zlp_pend_d;
    logic             tx_err_q, tx_err_d;
    logic             tx_done_q, tx_done_d;

    logic rx_strobe, rx_end, setup_ok, send_valid, byte_acc;

    assign rx_strobe  = rx_valid_i && rx_strb_i;
    assign rx_end     = rx_valid_i && rx_last_i;
    assign setup_ok   = rx_end && !rx_crc_err_i && rx_setup_i;
    assign send_valid = (state_q == ST_SEND) && !ep_stall_i;
    assign byte_acc   = send_valid && tx_data_accept_i;

    assign rx_space_o     = !rx_ready_q && !ep_stall_i;
    assign rx_push_o      = rx_strobe && (rx_len_q < MAX_L);
    assign rx_data_o      = rx_data_i;
    assign rx_length_o    = rx_len_q;
    assign rx_ready_o     = rx_ready_q;
    assign rx_err_o       = rx_err_q;
    assign rx_setup_o     = rx_setup_q;
    assign rx_dup_o       = rx_dup_q;
    assign tx_busy_o      = (state_q != ST_IDLE);
    assign tx_err_o       = tx_err_q;
    assign tx_done_o      = tx_done_q;
    assign tx_pid_data1_o = tx_tog_q;

    // Rx status and expected toggle; software ack wins over any same-cycle set
    always_comb begin
        rx_len_d   = rx_len_q;
        rx_ready_d = rx_ready_q;
        rx_err_d   = rx_err_q;
        rx_setup_d = rx_setup_q;
        rx_dup_d   = rx_dup_q;
        rx_tog_d   = rx_tog_q;
        if (rx_push_o) begin
            rx_len_d = rx_len_q + ONE_L;
        end
        if ((rx_strobe && rx_len_q == MAX_L) || (rx_push_o && rx_full_i)) begin
            rx_err_d = 1'b1;
        end
        if (rx_end) begin
            rx_ready_d = 1'b1;
            if (rx_crc_err_i) begin
                rx_err_d = 1'b1;
            end else if (rx_setup_i) begin
                rx_setup_d = 1'b1;
                rx_tog_d   = 1'b1;
            end else if (rx_pid_data1_i == rx_tog_q) begin
                rx_tog_d = !rx_tog_q;
            end else begin
                rx_dup_d = 1'b1;
            end
        end
        if (ep_toggle_clr_i) begin
            rx_tog_d = 1'b0;
        end
        if (rx_ack_i) begin
            rx_len_d   = '0;
            rx_ready_d = 1'b0;
            rx_err_d   = 1'b0;
            rx_setup_d = 1'b0;
            rx_dup_d   = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        remain_d   = remain_q;
        pkt_d      = pkt_q;
        zlp_pend_d = zlp_pend_q;
        tx_err_d   = tx_err_q;
        tx_done_d  = 1'b0;
        tx_tog_d   = tx_tog_q;
        case (state_q)
            ST_IDLE: begin
                if (tx_start_i) begin
                    remain_d   = tx_length_i;
                    pkt_d      = pkt_size(tx_length_i);
                    zlp_pend_d = ((tx_length_i == '0) ||
                                  (tx_zlp_en_i && (tx_length_i % MAX_L) == '0)) &&
                                 (pkt_size(tx_length_i) != '0);
                    tx_err_d   = 1'b0;
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                if (send_valid && (pkt_q != '0) && tx_empty_i) begin
                    tx_err_d = 1'b1;
                end
                if (byte_acc && (pkt_q != '0)) begin
                    pkt_d    = pkt_q - ONE_L;
                    remain_d = remain_q - ONE_L;
                end
                if (byte_acc && (pkt_q <= ONE_L)) begin
                    state_d = ST_WAIT_HS;
                end
            end
            ST_WAIT_HS: begin
                if (tx_hs_ack_i) begin
                    tx_tog_d = !tx_tog_q;
                    if ((remain_q == '0) && !zlp_pend_q) begin
                        tx_done_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        state_d = ST_SEND;
                        pkt_d   = pkt_size(remain_q);
                        if (pkt_size(remain_q) == '0) begin
                            zlp_pend_d = 1'b0;
                        end
                    end
                end else if (tx_hs_timeout_i) begin
                    tx_err_d = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A new SETUP cancels any IN transfer in flight, same as a flush
        if (tx_flush_i || (setup_ok && state_q != ST_IDLE)) begin
            state_d    = ST_IDLE;
            remain_d   = '0;
            pkt_d      = '0;
            zlp_pend_d = 1'b0;
            tx_err_d   = 1'b0;
            tx_done_d  = 1'b0;
        end
        if (setup_ok) begin
            tx_tog_d = 1'b1;
        end
        if (ep_toggle_clr_i) begin
            tx_tog_d = 1'b0;
        end
    end

    always_comb begin
        tx_ready_o      = 1'b0;
        tx_data_valid_o = 1'b0;
        tx_data_strb_o  = 1'b0;
        tx_data_last_o  = 1'b0;
        tx_data_o       = 8'd0;
        tx_pop_o        = 1'b0;
        if (state_q == ST_SEND) begin
            tx_ready_o      = send_valid;
            tx_data_valid_o = send_valid;
            tx_data_strb_o  = (pkt_q != '0);
            tx_data_last_o  = (pkt_q <= ONE_L);
            tx_pop_o        = byte_acc && (pkt_q != '0);
            if (send_valid && (pkt_q != '0)) begin
                tx_data_o = tx_data_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_len_q   <= '0;
            rx_ready_q <= 1'b0;
            rx_err_q   <= 1'b0;
            rx_setup_q <= 1'b0;
            rx_dup_q   <= 1'b0;
            rx_tog_q   <= 1'b0;
            tx_tog_q   <= 1'b0;
            state_q    <= ST_IDLE;
            zlp_pend_q <= 1'b0;
            tx_err_q   <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            rx_len_q   <= rx_len_d;
            rx_ready_q <= rx_ready_d;
            rx_err_q   <= rx_err_d;
            rx_setup_q <= rx_setup_d;
            rx_dup_q   <= rx_dup_d;
            rx_tog_q   <= rx_tog_d;
            tx_tog_q   <= tx_tog_d;
            state_q    <= state_d;
            zlp_pend_q <= zlp_pend_d;
            tx_err_q   <= tx_err_d;
            tx_done_q  <= tx_done_d;
        end
    end

    // Byte counters are only meaningful outside IDLE, so they carry no reset
    always_ff @(posedge clk_i) begin
        remain_q <= remain_d;
        pkt_q    <= pkt_d;
    end

endmodule

// File: tb/tb_usbf_sie_ep_mps.sv
// Directed bench for usbf_sie_ep_mps: table of IN transfers plus hand-written Rx/Tx corner sequences.
module tb_usbf_sie_ep_mps;
    localparam int LEN_W   = 11;
    localparam int MAX_PKT = 64;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic rst_i = 1'b0, ep_stall_i = 1'b0, ep_toggle_clr_i = 1'b0;
    logic rx_space_o, rx_setup_i = 1'b0, rx_valid_i = 1'b0, rx_strb_i = 1'b0;
    logic [7:0] rx_data_i = 8'd0, rx_data_o;
    logic rx_last_i = 1'b0, rx_crc_err_i = 1'b0, rx_pid_data1_i = 1'b0;
    logic rx_push_o, rx_full_i = 1'b0;
    logic [LEN_W-1:0] rx_length_o;
    logic rx_ready_o, rx_err_o, rx_setup_o, rx_dup_o, rx_ack_i = 1'b0;
    logic tx_pop_o, tx_empty_i = 1'b0, tx_flush_i = 1'b0;
    logic [7:0] tx_data_i = 8'd0, tx_data_o;
    logic [LEN_W-1:0] tx_length_i = '0;
    logic tx_zlp_en_i = 1'b0, tx_start_i = 1'b0;
    logic tx_busy_o, tx_err_o, tx_done_o, tx_ready_o, tx_data_valid_o, tx_data_strb_o;
    logic tx_data_last_o, tx_data_accept_i = 1'b0, tx_pid_data1_o;
    logic tx_hs_ack_i = 1'b0, tx_hs_timeout_i = 1'b0;

    usbf_sie_ep_mps #(.LEN_W(LEN_W), .MAX_PKT(MAX_PKT)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .ep_stall_i(ep_stall_i), .ep_toggle_clr_i(ep_toggle_clr_i),
        .rx_space_o(rx_space_o), .rx_setup_i(rx_setup_i), .rx_valid_i(rx_valid_i),
        .rx_strb_i(rx_strb_i), .rx_data_i(rx_data_i), .rx_last_i(rx_last_i),
        .rx_crc_err_i(rx_crc_err_i), .rx_pid_data1_i(rx_pid_data1_i), .rx_push_o(rx_push_o),
        .rx_data_o(rx_data_o), .rx_full_i(rx_full_i), .rx_length_o(rx_length_o),
        .rx_ready_o(rx_ready_o), .rx_err_o(rx_err_o), .rx_setup_o(rx_setup_o),
        .rx_dup_o(rx_dup_o), .rx_ack_i(rx_ack_i), .tx_pop_o(tx_pop_o), .tx_data_i(tx_data_i),
        .tx_empty_i(tx_empty_i), .tx_flush_i(tx_flush_i), .tx_length_i(tx_length_i),
        .tx_zlp_en_i(tx_zlp_en_i), .tx_start_i(tx_start_i), .tx_busy_o(tx_busy_o),
        .tx_err_o(tx_err_o), .tx_done_o(tx_done_o), .tx_ready_o(tx_ready_o),
        .tx_data_valid_o(tx_data_valid_o), .tx_data_strb_o(tx_data_strb_o),
        .tx_data_o(tx_data_o), .tx_data_last_o(tx_data_last_o),
        .tx_data_accept_i(tx_data_accept_i), .tx_pid_data1_o(tx_pid_data1_o),
        .tx_hs_ack_i(tx_hs_ack_i), .tx_hs_timeout_i(tx_hs_timeout_i)
    );

    int n_vec = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {rx_space_o, rx_push_o, rx_data_o, rx_length_o, rx_ready_o, rx_err_o,
                rx_setup_o, rx_dup_o, tx_pop_o, tx_busy_o, tx_err_o, tx_done_o, tx_ready_o,
                tx_data_valid_o, tx_data_strb_o, tx_data_o, tx_data_last_o, tx_pid_data1_o};
    endfunction

    // Results of the most recent IN transfer
    int got_npk, got_pops, got_done, got_lat, got_derr, got_fin;
    int got_sz[8];
    bit got_pid[8];

    task automatic run_tx(input int len, input bit zlp);
        int cur;
        cur = 0; got_npk = 0; got_pops = 0; got_done = 0; got_derr = 0; got_fin = 0;
        @(negedge clk_i);
        tx_length_i = len[LEN_W-1:0]; tx_zlp_en_i = zlp; tx_start_i = 1'b1;
        tx_data_accept_i = 1'b1;
        @(negedge clk_i);
        tx_start_i = 1'b0;
        got_lat = int'(tx_ready_o);
        for (int c = 0; c < 1000 && got_fin == 0; c++) begin
            tx_hs_ack_i = 1'b0;
            if (tx_done_o) got_done++;
            if (!tx_busy_o) begin
                got_fin = 1;
            end else if (tx_ready_o) begin
                if (tx_pop_o) got_pops++;
                if (tx_data_strb_o && tx_data_o !== tx_data_i) got_derr++;
                tx_data_i = tx_data_i + 8'd1;
                cur += tx_data_strb_o ? 1 : 0;
                if (tx_data_last_o) begin
                    if (got_npk < 8) begin
                        got_sz[got_npk]  = cur;
                        got_pid[got_npk] = tx_pid_data1_o;
                    end
                    got_npk++;
                    cur = 0;
                end
            end else begin
                tx_hs_ack_i = 1'b1;
            end
            if (got_fin == 0) @(negedge clk_i);
        end
        tx_hs_ack_i = 1'b0;
        @(negedge clk_i);
        if (tx_done_o) got_done++;
    endtask

    int got_push, got_rderr;

    task automatic send_out(input int n, input bit pid1, input bit setup, input bit crc);
        got_push = 0; got_rderr = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            rx_valid_i = 1'b1; rx_strb_i = 1'b1; rx_data_i = 8'(i + 3);
            rx_last_i = (i == n - 1); rx_pid_data1_i = pid1; rx_setup_i = setup;
            rx_crc_err_i = crc && (i == n - 1);
            #1;
            if (rx_push_o) begin
                got_push++;
                if (rx_data_o !== rx_data_i) got_rderr++;
            end
        end
        @(negedge clk_i);
        rx_valid_i = 1'b0; rx_strb_i = 1'b0; rx_data_i = 8'd0; rx_last_i = 1'b0;
        rx_pid_data1_i = 1'b0; rx_setup_i = 1'b0; rx_crc_err_i = 1'b0;
    endtask

    task automatic rx_ack();
        @(negedge clk_i); rx_ack_i = 1'b1;
        @(negedge clk_i); rx_ack_i = 1'b0;
    endtask

    task automatic tog_clr();
        @(negedge clk_i); ep_toggle_clr_i = 1'b1;
        @(negedge clk_i); ep_toggle_clr_i = 1'b0;
    endtask

    typedef struct {
        int len; bit zlp; int npk;
        int sz0; int sz1; int sz2;
        bit pid0; bit pid1; bit pid2;
        int pops;
    } txv_t;

    txv_t tv[7];

    initial begin
        int es[3];
        bit ep[3];
        tv[0] = '{150, 1'b1, 3, 64, 64, 22, 1'b0, 1'b1, 1'b0, 150};
        tv[1] = '{128, 1'b1, 3, 64, 64, 0,  1'b0, 1'b1, 1'b0, 128};
        tv[2] = '{128, 1'b0, 2, 64, 64, 0,  1'b0, 1'b1, 1'b0, 128};
        tv[3] = '{0,   1'b0, 1, 0,  0,  0,  1'b0, 1'b0, 1'b0, 0};
        tv[4] = '{64,  1'b0, 1, 64, 0,  0,  1'b0, 1'b0, 1'b0, 64};
        tv[5] = '{1,   1'b1, 1, 1,  0,  0,  1'b0, 1'b0, 1'b0, 1};
        tv[6] = '{64,  1'b1, 2, 64, 0,  0,  1'b0, 1'b1, 1'b0, 64};

        // Reset with the endpoint halted so rx_space_o is 0 as well
        @(negedge clk_i); rst_i = 1'b1; ep_stall_i = 1'b1;
        @(negedge clk_i);
        chk("reset_outputs", all_outs(), 64'd0);
        rst_i = 1'b0; ep_stall_i = 1'b0;
        @(negedge clk_i);
        chk("space_after_reset", rx_space_o, 1);

        for (int v = 0; v < 7; v++) begin
            tog_clr();
            run_tx(tv[v].len, tv[v].zlp);
            es = '{tv[v].sz0, tv[v].sz1, tv[v].sz2};
            ep = '{tv[v].pid0, tv[v].pid1, tv[v].pid2};
            chk($sformatf("v%0d_finished", v), got_fin, 1);
            chk($sformatf("v%0d_latency", v), got_lat, 1);
            chk($sformatf("v%0d_npkts", v), got_npk, tv[v].npk);
            chk($sformatf("v%0d_pops", v), got_pops, tv[v].pops);
            chk($sformatf("v%0d_done_pulses", v), got_done, 1);
            chk($sformatf("v%0d_data_errs", v), got_derr, 0);
            chk($sformatf("v%0d_tx_err", v), tx_err_o, 0);
            for (int i = 0; i < tv[v].npk && i < got_npk && i < 3; i++) begin
                chk($sformatf("v%0d_pkt%0d_size", v, i), got_sz[i], es[i]);
                chk($sformatf("v%0d_pkt%0d_pid", v, i), got_pid[i], ep[i]);
            end
        end

        // OUT toggles: D0 accepted, D0 duplicate, D1 accepted, then D0 expected
        send_out(4, 1'b0, 1'b0, 1'b0);
        chk("out1_push", got_push, 4);
        chk("out1_status", {rx_ready_o, rx_err_o, rx_dup_o, rx_space_o}, 4'b1000);
        chk("out1_len", rx_length_o, 4);
        chk("out1_data", got_rderr, 0);
        rx_ack();
        chk("out1_ack", {rx_ready_o, rx_space_o, rx_length_o}, {2'b01, 11'd0});
        send_out(4, 1'b0, 1'b0, 1'b0);
        chk("out2_dup", {rx_ready_o, rx_dup_o}, 2'b11);
        rx_ack();
        chk("out2_ack", rx_dup_o, 0);
        send_out(3, 1'b1, 1'b0, 1'b0);
        chk("out3_nodup", {rx_ready_o, rx_dup_o}, 2'b10);
        chk("out3_len", rx_length_o, 3);
        rx_ack();
        send_out(2, 1'b0, 1'b0, 1'b0);
        chk("out4_d0_expected", rx_dup_o, 0);
        rx_ack();

        // Oversize OUT: babble past MAX_PKT
        send_out(70, 1'b1, 1'b0, 1'b0);
        chk("babble_push", got_push, 64);
        chk("babble_len", rx_length_o, 64);
        chk("babble_err", {rx_err_o, rx_dup_o}, 2'b10);
        rx_ack();
        chk("babble_ack", {rx_ready_o, rx_err_o, rx_setup_o, rx_dup_o, rx_length_o}, 15'd0);

        // CRC error leaves the expected toggle alone
        send_out(2, 1'b0, 1'b0, 1'b1);
        chk("crc_err", {rx_ready_o, rx_err_o, rx_dup_o}, 3'b110);
        rx_ack();
        send_out(1, 1'b0, 1'b0, 1'b0);
        chk("crc_toggle_kept", rx_dup_o, 0);
        rx_ack();
        rx_full_i = 1'b1;
        send_out(2, 1'b1, 1'b0, 1'b0);
        rx_full_i = 1'b0;
        chk("full_err", rx_err_o, 1);
        rx_ack();

        // SETUP arriving mid-IN aborts Tx and forces DATA1 both ways
        tog_clr();
        @(negedge clk_i);
        tx_length_i = 11'd150; tx_zlp_en_i = 1'b0; tx_start_i = 1'b1; tx_data_accept_i = 1'b1;
        @(negedge clk_i); tx_start_i = 1'b0;
        repeat (10) @(negedge clk_i);
        chk("setup_pre_busy", tx_busy_o, 1);
        send_out(8, 1'b0, 1'b1, 1'b0);
        chk("setup_tx_abort", tx_busy_o, 0);
        chk("setup_flags", {rx_ready_o, rx_setup_o}, 2'b11);
        chk("setup_tx_pid", tx_pid_data1_o, 1);
        rx_ack();
        send_out(2, 1'b1, 1'b0, 1'b0);
        chk("setup_rx_d1", rx_dup_o, 0);
        rx_ack();
        run_tx(1, 1'b0);
        chk("setup_in_pid", got_pid[0], 1);
        run_tx(1, 1'b0);
        chk("in_pid_d0", got_pid[0], 0);
        chk("pid_before_clr", tx_pid_data1_o, 1);
        tog_clr();
        chk("pid_after_clr", tx_pid_data1_o, 0);

        // Handshake timeout
        @(negedge clk_i);
        tx_length_i = 11'd10; tx_start_i = 1'b1;
        @(negedge clk_i); tx_start_i = 1'b0;
        for (int c = 0; c < 50 && !(tx_busy_o && !tx_ready_o); c++) @(negedge clk_i);
        chk("wait_hs_reached", tx_busy_o && !tx_ready_o, 1);
        tx_hs_timeout_i = 1'b1;
        @(negedge clk_i); tx_hs_timeout_i = 1'b0;
        chk("timeout_err_busy", {tx_err_o, tx_busy_o}, 2'b10);
        chk("timeout_pid_kept", tx_pid_data1_o, 0);

        // Underrun then flush
        tx_empty_i = 1'b1;
        tx_length_i = 11'd5; tx_start_i = 1'b1;
        @(negedge clk_i); tx_start_i = 1'b0;
        @(negedge clk_i);
        chk("underrun_err_busy", {tx_err_o, tx_busy_o}, 2'b11);
        tx_flush_i = 1'b1;
        @(negedge clk_i); tx_flush_i = 1'b0; tx_empty_i = 1'b0;
        chk("flush_idle", {tx_err_o, tx_busy_o}, 2'b00);

        // Reset in the middle of a second packet with Rx status pending
        send_out(3, 1'b1, 1'b0, 1'b0);
        @(negedge clk_i);
        tx_length_i = 11'd100; tx_start_i = 1'b1;
        @(negedge clk_i); tx_start_i = 1'b0;
        for (int c = 0; c < 75; c++) begin
            tx_hs_ack_i = tx_busy_o && !tx_ready_o;
            @(negedge clk_i);
        end
        tx_hs_ack_i = 1'b0;
        chk("pre_reset_state", {tx_busy_o, tx_pid_data1_o, rx_ready_o}, 3'b111);
        rst_i = 1'b1; ep_stall_i = 1'b1; tx_data_accept_i = 1'b0; tx_data_i = 8'd0;
        @(negedge clk_i);
        chk("reset_mid_packet", all_outs(), 64'd0);
        rst_i = 1'b0; ep_stall_i = 1'b0;
        @(negedge clk_i);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
